// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit owning the HI/LO pair
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t state, state_next;

    logic [1:0]         op_q;      // op[1]: divide, op[0]: unsigned
    logic               sa;
    logic               sb;
    logic               b_zero;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;       // product accumulator or {remainder, quotient}
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    // Operand magnitudes at issue, one radix-2 step, and final sign correction
    always_comb begin
        abs_a     = (~op[0] & src_a[WIDTH-1]) ? -src_a : src_a;
        abs_b     = (~op[0] & src_b[WIDTH-1]) ? -src_b : src_b;
        addend    = acc[0] ? opnd : '0;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        if (!op_q[1]) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {acc[2*WIDTH-2:0], 1'b0};
        end
        prod_fix = (sa ^ sb) ? -acc : acc;
        q_fix    = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix    = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: IDLE -> CALC on start, CALC for WIDTH steps, one FIX cycle
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_CALC;
            S_CALC: if (cnt == CNT_W'(WIDTH - 1)) state_next = S_FIX;
            S_FIX:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, HI/LO writes and done pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q   <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            b_zero <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (start) begin
                        op_q   <= op;
                        sa     <= ~op[0] & src_a[WIDTH-1];
                        sb     <= ~op[0] & src_b[WIDTH-1];
                        b_zero <= (src_b == '0);
                        cnt    <= '0;
                        acc    <= {{WIDTH{1'b0}}, abs_a};
                        opnd   <= abs_b;
                    end
                end
                S_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (!op_q[1]) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else begin
                        // Zero divisor leaves the dividend as remainder; quotient is forced to all ones
                        hi_q <= r_fix;
                        lo_q <= b_zero ? '1 : q_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != S_IDLE);
    assign stall  = start | busy;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
